bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares one simple-dual-port BRAM (1 write port, 1 read port, 1-cycle read latency, read-first) between two requesters, A and B.
- Typical pairing: A is the processor datapath and B is the host/loader path, with both accessing the same scratchpad.
- Reads and writes are arbitrated independently with round-robin, so one read and one write can complete per cycle.
- Adds same-cycle write-to-read forwarding so requesters see write-first semantics.

Parameters:
- DATA_WIDTH, 16, width of a memory word.
- ADDRESS_WIDTH, 11, address width; depth is 2^ADDRESS_WIDTH.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req_valid  in  1  A presents a request.
- a_req_ready  out  1  A request accepted this cycle (handshake = valid & ready).
- a_req_wen  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDRESS_WIDTH  word address.
- a_req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- a_resp_valid  out  1  read data valid for A.
- a_resp_data  out  DATA_WIDTH  read data for A.
- b_req_valid, b_req_ready, b_req_wen, b_req_addr, b_req_wdata, b_resp_valid, b_resp_data: identical to the A ports, for requester B.

Behaviour:
- Reset:
  - a/b_req_ready=0 while reset is high; a/b_resp_valid=0 and a/b_resp_data=0 in the cycle after reset is sampled.
  - Read and write round-robin pointers reset to A.
  - Memory contents are not cleared.
- Arbitration (combinational, per cycle):
  - Read candidates: requesters with valid & !wen. Write candidates: requesters with valid & wen.
  - Read port: one candidate → grant it. Two candidates → grant the one the read pointer names.
  - Write port: same rule, using the write pointer.
  - A requester's ready = its grant. Ready may depend on valid; valid must not depend on ready.
  - Example: A reads and B writes in the same cycle → both are granted.
- Pointer update:
  - After a contested grant (both candidates valid), that port's pointer moves to the loser.
  - After an uncontested grant, the pointer moves to the non-granted requester.
  - With no grant, the pointer holds.
- Memory drive:
  - Memory wen = any write grant; waddr/din come from the write winner.
  - raddr comes from the read winner (hold the last value when idle).
- Read latency:
  - A read accepted in cycle t gives resp_valid=1 for exactly one cycle at t+1 on the granted requester's response port.
  - resp_data holds its last value when resp_valid=0.
  - There is no response backpressure.
- Forwarding:
  - If a read and a write are granted in the same cycle to the same address, the response at t+1 carries the write data, not the old memory content.
  - Implement by registering a match flag and the write data at t, then muxing at t+1.
  - Also applies when the same requester is not involved (A reads, B writes).
- Write-then-read: a write at t followed by a read of the same address at t+1 returns the new data, because the memory is already updated.
- Reset mid-operation: a read accepted in the cycle reset asserts produces no response (resp_valid=0 at t+1).
- Address bits beyond ADDRESS_WIDTH do not exist; no range checking.

Decomposition:
- Shared package holds:
  - a req_t struct (wen, addr, wdata);
  - enum requester_e {REQ_A, REQ_B};
  - localparams for the default widths.
- Natural sub-module: rr_arbiter2, a 2-way round-robin grant with a registered pointer. It is instantiated twice, for the read and write ports.
- The storage is the team's existing BRAMLike primitive, instantiated with matching parameters.

Test Plan:
- Basic read/write:
  - A writes addr 0x010 = 0xBEEF at t0; A reads 0x010 at t1.
  - a_resp_valid=1 at t2 with data 0xBEEF; b_resp_valid stays 0.
- Contested reads, round-robin:
  - A and B both read (0x001 pre-written 0x1111, 0x002 pre-written 0x2222) held valid for 4 cycles.
  - Grants go A,B,A,B; responses arrive 1 cycle later with 0x1111/0x2222 on the correct ports.
- Concurrent read + write:
  - A reads 0x020 while B writes 0x020=0x5A5A in the same cycle.
  - Both ready=1; a_resp_data=0x5A5A at t+1 (forwarding).
  - A following read of 0x020 also returns 0x5A5A.
- Contested writes:
  - A writes 0x030=0x0001 and B writes 0x030=0x0002 at t0 with pointer=A.
  - Only A is ready at t0; B is ready at t1.
  - A read of 0x030 at t3 returns 0x0002.
- Reset behaviour:
  - Assert reset in the cycle an A read is accepted.
  - a_resp_valid=0 next cycle; both ready=0 during reset; both pointers = A afterwards.
  - Memory data written before reset is still readable.
- Idle hold:
  - No valid for 5 cycles → no memory write, resp_valid=0 throughout, pointers unchanged.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// rtl/bram_port_arbiter_pkg.sv - shared types and defaults for the two-requester BRAM port arbiter
package bram_port_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 11;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } requester_e;

  typedef struct packed {
    logic                             wen;
    logic [DEFAULT_ADDRESS_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0]    wdata;
  } req_t;

  function automatic requester_e other_requester(input requester_e r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/BRAMLike.sv
// rtl/BRAMLike.sv - simple-dual-port block RAM, one write port, one read port, read-first, 1-cycle read
module BRAMLike #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clock,
  input  logic                     wen,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDRESS_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (wen) begin
      mem[waddr] <= din;
    end
    dout <= mem[raddr];
  end

endmodule

// File: rtl/bram_port_arbiter_rr_arbiter2.sv
// rtl/bram_port_arbiter_rr_arbiter2.sv - two-way round-robin grant with a registered turn pointer
module bram_port_arbiter_rr_arbiter2
  import bram_port_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  requester_e ptr_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
    end
  end

  // Any grant hands the next turn to whichever requester did not win.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= REQ_A;
    end else if (|grant) begin
      ptr_q <= other_requester(grant[0] ? REQ_A : REQ_B);
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one simple-dual-port BRAM between requesters A and B with
// independent read/write round-robin and same-cycle write-to-read forwarding
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     a_req_valid,
  output logic                     a_req_ready,
  input  logic                     a_req_wen,
  input  logic [ADDRESS_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0]    a_req_wdata,
  output logic                     a_resp_valid,
  output logic [DATA_WIDTH-1:0]    a_resp_data,
  input  logic                     b_req_valid,
  output logic                     b_req_ready,
  input  logic                     b_req_wen,
  input  logic [ADDRESS_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0]    b_req_wdata,
  output logic                     b_resp_valid,
  output logic [DATA_WIDTH-1:0]    b_resp_data
);

  req_t a_req;
  req_t b_req;

  assign a_req = '{wen: a_req_wen, addr: a_req_addr, wdata: a_req_wdata};
  assign b_req = '{wen: b_req_wen, addr: b_req_addr, wdata: b_req_wdata};

  logic [1:0] rd_cand;
  logic [1:0] wr_cand;
  logic [1:0] rd_grant;
  logic [1:0] wr_grant;

  // Candidates are masked during reset so nothing is accepted while it is high.
  assign rd_cand = {b_req_valid & ~b_req.wen, a_req_valid & ~a_req.wen} & {2{~reset}};
  assign wr_cand = {b_req_valid &  b_req.wen, a_req_valid &  a_req.wen} & {2{~reset}};

  bram_port_arbiter_rr_arbiter2 u_rd_arb (
    .clock (clock),
    .reset (reset),
    .req   (rd_cand),
    .grant (rd_grant)
  );

  bram_port_arbiter_rr_arbiter2 u_wr_arb (
    .clock (clock),
    .reset (reset),
    .req   (wr_cand),
    .grant (wr_grant)
  );

  assign a_req_ready = rd_grant[0] | wr_grant[0];
  assign b_req_ready = rd_grant[1] | wr_grant[1];

  logic                     rd_any;
  logic                     wr_any;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [ADDRESS_WIDTH-1:0] mem_raddr;
  logic [ADDRESS_WIDTH-1:0] raddr_q;
  logic [DATA_WIDTH-1:0]    mem_dout;

  assign rd_any    = |rd_grant;
  assign wr_any    = |wr_grant;
  assign rd_addr   = rd_grant[1] ? b_req.addr  : a_req.addr;
  assign wr_addr   = wr_grant[1] ? b_req.addr  : a_req.addr;
  assign wr_data   = wr_grant[1] ? b_req.wdata : a_req.wdata;
  assign mem_raddr = rd_any ? rd_addr : raddr_q;

  BRAMLike #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_mem (
    .clock (clock),
    .wen   (wr_any),
    .waddr (wr_addr),
    .din   (wr_data),
    .raddr (mem_raddr),
    .dout  (mem_dout)
  );

  logic                  resp_a_q;
  logic                  resp_b_q;
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [DATA_WIDTH-1:0] hold_a_q;
  logic [DATA_WIDTH-1:0] hold_b_q;
  logic [DATA_WIDTH-1:0] rdata;

  // The BRAM is read-first, so a same-cycle same-address write is patched in here.
  assign rdata = fwd_q ? fwd_data_q : mem_dout;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_a_q   <= 1'b0;
      resp_b_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      raddr_q    <= '0;
    end else begin
      resp_a_q   <= rd_grant[0];
      resp_b_q   <= rd_grant[1];
      fwd_q      <= rd_any & wr_any & (rd_addr == wr_addr);
      fwd_data_q <= wr_data;
      raddr_q    <= mem_raddr;
      if (resp_a_q) begin
        hold_a_q <= rdata;
      end
      if (resp_b_q) begin
        hold_b_q <= rdata;
      end
    end
  end

  assign a_resp_valid = resp_a_q;
  assign b_resp_valid = resp_b_q;
  assign a_resp_data  = resp_a_q ? rdata : hold_a_q;
  assign b_resp_data  = resp_b_q ? rdata : hold_b_q;

endmodule
